// File: rtl/timing_nco.sv
// Timing-recovery NCO: a down-counting phase accumulator that emits interpolant strobes,
// symbol-centre flags and the fractional interval mu, with the step steered by a loop-filter correction.
module timing_nco #(
  parameter int unsigned WERR       = 18,
  parameter int unsigned NCO_WIDTH  = 24,
  parameter int unsigned CTRL_SHIFT = 6,
  parameter int unsigned MU_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_val_i,
  input  logic signed [WERR-1:0] ctrl_i,
  input  logic                   ctrl_val_i,
  output logic                   strobe_o,
  output logic                   sym_o,
  output logic [MU_W-1:0]        mu_o,
  output logic                   clamp_o
);

  // Two guard bits so NOM plus the shifted correction cannot overflow before clamping.
  localparam int unsigned SW = NCO_WIDTH + 2;

  localparam logic signed [SW-1:0] NOM      = SW'(1) <<< (NCO_WIDTH - 1);
  localparam logic signed [SW-1:0] STEP_MIN = NOM - (NOM >>> 2);
  localparam logic signed [SW-1:0] STEP_MAX = NOM + (NOM >>> 2);

  logic signed [WERR-1:0]  ctrl_q;
  logic [NCO_WIDTH-1:0]    eta;
  logic                    flag;

  logic signed [SW-1:0]    ctrl_ext;
  logic signed [SW-1:0]    step_wide;
  logic [NCO_WIDTH-1:0]    step;
  logic                    clamped;
  logic                    underflow;

  // Step from the held correction, saturated to +/-25% of nominal.
  always_comb begin
    ctrl_ext  = {{(SW - WERR){ctrl_q[WERR-1]}}, ctrl_q};
    step_wide = NOM + (ctrl_ext <<< CTRL_SHIFT);
    step      = step_wide[NCO_WIDTH-1:0];
    clamped   = 1'b0;
    if (step_wide > STEP_MAX) begin
      step    = STEP_MAX[NCO_WIDTH-1:0];
      clamped = 1'b1;
    end else if (step_wide < STEP_MIN) begin
      step    = STEP_MIN[NCO_WIDTH-1:0];
      clamped = 1'b1;
    end
    underflow = (eta < step);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      eta      <= '1;
      flag     <= 1'b0;
      strobe_o <= 1'b0;
      sym_o    <= 1'b0;
      mu_o     <= '0;
      clamp_o  <= 1'b0;
    end else begin
      strobe_o <= 1'b0;
      sym_o    <= 1'b0;
      clamp_o  <= 1'b0;
      // A coincident correction only takes effect from the following advance.
      if (ctrl_val_i) begin
        ctrl_q <= ctrl_i;
      end
      if (in_val_i) begin
        eta     <= eta - step;
        clamp_o <= clamped;
        if (underflow) begin
          strobe_o <= 1'b1;
          sym_o    <= flag;
          flag     <= ~flag;
          mu_o     <= eta[NCO_WIDTH-2 -: MU_W];
        end
      end
    end
  end

endmodule
